paddle_quad_ctrl: RTL and testbench
===================================

Name: paddle_quad_ctrl

Overview:
- Upstream stage of the video generator. Converts a mechanical quadrature rotary encoder into the 10-bit PaddleX column that the video generator consumes.
- Synchronizes and glitch-filters the encoder inputs, then decodes them into signed counts and accumulates those counts.
- Applies the accumulated movement once per frame, on the rising edge of vSync. The paddle therefore never moves mid-frame, and PaddleX is always clamped to the playfield.

Parameters:
FILT_LEN, 4, consecutive identical synchronized samples required before a filtered channel changes (range 1..15)
STEP, 4, pixels moved per decoded quadrature count (range 1..15)
DELTA_W, 8, width of the signed count accumulator
PADDLE_MIN, 8, minimum legal PaddleX
PADDLE_MAX, 568, maximum legal PaddleX
PADDLE_INIT, 288, PaddleX after reset

Ports:
clk  in  1  pixel clock, shared with video generator
rst_n  in  1  asynchronous active-low reset
quadA  in  1  encoder channel A, asynchronous
quadB  in  1  encoder channel B, asynchronous
vSync  in  1  registered vSync from the video generator, active high
PaddleX  out  10  paddle left column, fed to the video generator PaddleX input
moved  out  1  one-cycle pulse when PaddleX changes value
step_err  out  1  one-cycle pulse on an illegal quadrature transition

Behaviour:
Reset (all state asynchronous on rst_n low):
- Synchronizer flops = 0, filtered A/B = 0, previous state = 00, filter counters = 0.
- Accumulator = 0, vSync_d = 0.
- PaddleX = PADDLE_INIT, moved = 0, step_err = 0.

Input path:
- quadA and quadB each pass through a 2-flop synchronizer.
- Glitch filter, per channel: a 4-bit counter.
  - Counter clears when the synchronized value equals the filtered value.
  - Otherwise it increments. When it reaches FILT_LEN-1 with a still-differing sample, the filtered value takes the sample and the counter clears.
  - Latency from input edge to filtered edge = 2 + FILT_LEN cycles.

Decoder:
- Compare the previous filtered state {A,B} with the current one each cycle.
- Forward sequence 00->01->11->10->00 gives +1. Reverse sequence gives -1. No change gives 0.
- Both bits changing is illegal: step_err = 1 for exactly that cycle, count 0, and the previous state still updates to the current one.
- Registered outputs: count and step_err appear one cycle after the filtered change.

Accumulator:
- Signed, DELTA_W bits.
- Saturates at +(2^(DELTA_W-1)-1) and -(2^(DELTA_W-1)-1); further counts in the same direction are dropped.

Frame update:
- vSync_d registers vSync. The frame tick is vSync & ~vSync_d.
- On a frame tick:
  - next = PaddleX + acc*STEP, computed signed at 10+DELTA_W+4 bits.
  - PaddleX <= PADDLE_MIN if next < PADDLE_MIN; PADDLE_MAX if next > PADDLE_MAX; else next.
  - moved = 1 on the following cycle if and only if the new PaddleX differs from the old one.
- Simultaneous events: if a decoder count arrives on the frame-tick cycle, the tick uses the old accumulator value and the accumulator reloads with that count (not 0). Nothing is lost.
- Outside frame ticks, PaddleX is held constant. vSync held high produces exactly one tick.
- Reset asserted mid-frame: PaddleX returns to PADDLE_INIT immediately and any pending accumulation is discarded.

Test Plan:
- Reset, then 10 forward quadrature cycles (40 counts, each edge held 20 clk), then one vSync pulse. Required: PaddleX = 288+160 = 448, moved pulses once. A second vSync with no motion leaves PaddleX at 448 and moved = 0.
- From 448, 100 forward counts then vSync. Required: PaddleX clamps to 568. Then 200 reverse counts then vSync: accumulator saturates at -127, next = 568-508 = 60, so PaddleX = 60. Then 20 more reverse counts: 60-80 < 8, so PaddleX clamps to 8.
- 1-cycle and 3-cycle glitches on quadA with FILT_LEN=4. Required: no count, PaddleX unchanged after vSync, step_err = 0.
- Filtered state forced from 00 to 11 (both inputs change together and stay stable). Required: step_err single-cycle pulse, accumulator unchanged, and the next legal edge 11->10 counts +1.
- Decoder count aligned to the same cycle as the vSync rising edge, with accumulator = 5. Required: PaddleX += 20, accumulator = 1 afterwards, and the following vSync adds 4.
- rst_n pulsed low asynchronously mid-frame with accumulator = 30. Required: PaddleX = 288 within the reset, and the next vSync leaves PaddleX at 288.

Source files
------------

// File: rtl/paddle_quad_ctrl.sv
// rtl/paddle_quad_ctrl.sv - quadrature encoder to per-frame clamped PaddleX column
module paddle_quad_ctrl #(
  parameter int FILT_LEN    = 4,
  parameter int STEP        = 4,
  parameter int DELTA_W     = 8,
  parameter int PADDLE_MIN  = 8,
  parameter int PADDLE_MAX  = 568,
  parameter int PADDLE_INIT = 288
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       quadA,
  input  logic       quadB,
  input  logic       vSync,
  output logic [9:0] PaddleX,
  output logic       moved,
  output logic       step_err
);
  // Next-position arithmetic is wide enough that acc*STEP can never wrap.
  localparam int NW = 10 + DELTA_W + 4;
  localparam logic [3:0]                FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic signed [DELTA_W-1:0] ACC_ONE   = DELTA_W'(1);
  localparam logic signed [DELTA_W-1:0] ACC_MAX   = {1'b0, {(DELTA_W-1){1'b1}}};
  localparam logic signed [DELTA_W-1:0] ACC_MIN   = -ACC_MAX;
  localparam logic signed [NW-1:0]      STEP_EXT  = NW'(STEP);
  localparam logic signed [NW-1:0]      MIN_EXT   = NW'(PADDLE_MIN);
  localparam logic signed [NW-1:0]      MAX_EXT   = NW'(PADDLE_MAX);

  logic                      r_a_meta, r_a_sync, r_b_meta, r_b_sync;
  logic                      r_a_filt, r_b_filt;
  logic [3:0]                r_a_cnt, r_b_cnt;
  logic [1:0]                r_prev;
  logic                      r_cnt_up, r_cnt_dn, r_step_err;
  logic signed [DELTA_W-1:0] r_acc;
  logic                      r_vsync_d;
  logic [9:0]                r_paddle;
  logic                      r_moved;

  logic [1:0]                w_cur;
  logic                      w_up, w_dn, w_bad;
  logic                      w_tick;
  logic signed [NW-1:0]      w_acc_ext;
  logic signed [NW-1:0]      w_next;
  logic [9:0]                w_new;

  // Two-flop synchronizers for the asynchronous encoder channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= quadA;
      r_a_sync <= r_a_meta;
      r_b_meta <= quadB;
      r_b_sync <= r_b_meta;
    end
  end

  // Channel A glitch filter: accept a new level only after FILT_LEN stable samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_filt <= 1'b0;
      r_a_cnt  <= 4'd0;
    end else if (r_a_sync == r_a_filt) begin
      r_a_cnt  <= 4'd0;
    end else if (r_a_cnt >= FILT_LAST) begin
      r_a_filt <= r_a_sync;
      r_a_cnt  <= 4'd0;
    end else begin
      r_a_cnt  <= r_a_cnt + 4'd1;
    end
  end

  // Channel B glitch filter, identical to channel A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_filt <= 1'b0;
      r_b_cnt  <= 4'd0;
    end else if (r_b_sync == r_b_filt) begin
      r_b_cnt  <= 4'd0;
    end else if (r_b_cnt >= FILT_LAST) begin
      r_b_filt <= r_b_sync;
      r_b_cnt  <= 4'd0;
    end else begin
      r_b_cnt  <= r_b_cnt + 4'd1;
    end
  end

  assign w_cur = {r_a_filt, r_b_filt};

  // Classify the previous->current filtered state as forward, reverse or illegal.
  always_comb begin
    w_up  = 1'b0;
    w_dn  = 1'b0;
    w_bad = 1'b0;
    case ({r_prev, w_cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_up  = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_dn  = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_bad = 1'b1;
      default: ;
    endcase
  end

  // Register the decoded count; previous state always follows, even on illegal jumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= 2'b00;
      r_cnt_up   <= 1'b0;
      r_cnt_dn   <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      r_prev     <= w_cur;
      r_cnt_up   <= w_up;
      r_cnt_dn   <= w_dn;
      r_step_err <= w_bad;
    end
  end

  assign w_tick    = vSync & ~r_vsync_d;
  assign w_acc_ext = {{(NW-DELTA_W){r_acc[DELTA_W-1]}}, r_acc};
  assign w_next    = $signed({{(NW-10){1'b0}}, r_paddle}) + w_acc_ext * STEP_EXT;

  // Clamp the candidate position to the playfield.
  always_comb begin
    w_new = w_next[9:0];
    if (w_next < MIN_EXT) begin
      w_new = 10'(PADDLE_MIN);
    end else if (w_next > MAX_EXT) begin
      w_new = 10'(PADDLE_MAX);
    end
  end

  // Saturating movement accumulator; a count landing on the tick seeds the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_tick) begin
      if (r_cnt_up) begin
        r_acc <= ACC_ONE;
      end else if (r_cnt_dn) begin
        r_acc <= -ACC_ONE;
      end else begin
        r_acc <= '0;
      end
    end else if (r_cnt_up && (r_acc != ACC_MAX)) begin
      r_acc <= r_acc + ACC_ONE;
    end else if (r_cnt_dn && (r_acc != ACC_MIN)) begin
      r_acc <= r_acc - ACC_ONE;
    end
  end

  // Apply movement once per frame on the vSync rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_paddle  <= 10'(PADDLE_INIT);
      r_moved   <= 1'b0;
    end else begin
      r_vsync_d <= vSync;
      if (w_tick) begin
        r_paddle <= w_new;
        r_moved  <= (w_new != r_paddle);
      end else begin
        r_moved  <= 1'b0;
      end
    end
  end

  assign PaddleX  = r_paddle;
  assign moved    = r_moved;
  assign step_err = r_step_err;
endmodule

// File: tb/tb_paddle_quad_ctrl.sv
// tb/tb_paddle_quad_ctrl.sv - randomized self-checking bench for paddle_quad_ctrl
module tb_paddle_quad_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       quadA = 1'b0;
  logic       quadB = 1'b0;
  logic       vSync = 1'b0;
  logic [9:0] PaddleX;
  logic       moved;
  logic       step_err;

  int checks = 0;
  int errors = 0;
  int moved_cnt = 0;
  int err_cnt = 0;
  int m_paddle = 288;
  int m_acc = 0;
  int pos = 0;

  paddle_quad_ctrl dut (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .vSync(vSync),
    .PaddleX(PaddleX), .moved(moved), .step_err(step_err)
  );

  always #5 clk = ~clk;

  // Count high cycles of the pulse outputs, sampled away from the active edge.
  always @(negedge clk) begin
    if (moved) moved_cnt++;
    if (step_err) err_cnt++;
  end

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int clampp(input int v);
    if (v < 8) return 8;
    if (v > 568) return 568;
    return v;
  endfunction

  task automatic apply_pos();
    case (pos)
      0: begin quadA = 1'b0; quadB = 1'b0; end
      1: begin quadA = 1'b0; quadB = 1'b1; end
      2: begin quadA = 1'b1; quadB = 1'b1; end
      default: begin quadA = 1'b1; quadB = 1'b0; end
    endcase
  endtask

  task automatic step(input int dir, input int hold);
    pos = (pos + dir + 4) % 4;
    apply_pos();
    m_acc = sat(m_acc + dir);
    repeat (hold) @(negedge clk);
  endtask

  task automatic frame(input string name, input int hold);
    int old_p;
    int mc0;
    int exp_m;
    repeat (12) @(negedge clk);
    old_p = m_paddle;
    m_paddle = clampp(m_paddle + m_acc * 4);
    m_acc = 0;
    exp_m = (m_paddle != old_p) ? 1 : 0;
    mc0 = moved_cnt;
    vSync = 1'b1;
    repeat (hold) @(negedge clk);
    vSync = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (PaddleX !== 10'(m_paddle)) begin
      errors++;
      $display("FAIL %s PaddleX got %0d want %0d", name, PaddleX, m_paddle);
    end
    checks++;
    if (moved_cnt - mc0 != exp_m) begin
      errors++;
      $display("FAIL %s moved_cycles got %0d want %0d", name, moved_cnt - mc0, exp_m);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quadA = 1'b0;
    quadB = 1'b0;
    vSync = 1'b0;
    pos = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_paddle = 288;
    m_acc = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (PaddleX !== 10'd288) begin errors++; $display("FAIL reset_paddle got %0d want 288", PaddleX); end
    checks++;
    if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved got %b want 0", moved); end
    checks++;
    if (step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err got %b want 0", step_err); end
    do_reset();
  endtask

  task automatic test_forward();
    for (int i = 0; i < 40; i++) step(1, 20);
    frame("fwd40", 3);
    checks++;
    if (PaddleX !== 10'd448) begin errors++; $display("FAIL fwd40_const got %0d want 448", PaddleX); end
    frame("fwd_idle", 3);
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 100; i++) step(1, 8);
    frame("clamp_max", 3);
    checks++;
    if (PaddleX !== 10'd568) begin errors++; $display("FAIL clamp_max_const got %0d want 568", PaddleX); end
    for (int i = 0; i < 200; i++) step(-1, 8);
    frame("sat_neg", 3);
    checks++;
    if (PaddleX !== 10'd60) begin errors++; $display("FAIL sat_neg_const got %0d want 60", PaddleX); end
    for (int i = 0; i < 20; i++) step(-1, 8);
    frame("clamp_min", 3);
    checks++;
    if (PaddleX !== 10'd8) begin errors++; $display("FAIL clamp_min_const got %0d want 8", PaddleX); end
  endtask

  task automatic test_glitch();
    int e0;
    int lens[4];
    do_reset();
    e0 = err_cnt;
    lens[0] = 1;
    lens[1] = 3;
    lens[2] = $urandom_range(1, 3);
    lens[3] = $urandom_range(1, 3);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        quadA = ~quadA;
        repeat (lens[i]) @(negedge clk);
        quadA = ~quadA;
      end else begin
        quadB = ~quadB;
        repeat (lens[i]) @(negedge clk);
        quadB = ~quadB;
      end
      repeat (10) @(negedge clk);
    end
    frame("glitch", 3);
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL glitch_step_err got %0d want %0d", err_cnt - e0, 0); end
  endtask

  task automatic test_illegal();
    int e0;
    do_reset();
    e0 = err_cnt;
    quadA = 1'b1;
    quadB = 1'b1;
    pos = 2;
    repeat (20) @(negedge clk);
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL illegal_err_cycles got %0d want 1", err_cnt - e0); end
    frame("illegal_noacc", 3);
    step(1, 20);
    frame("illegal_then_fwd", 3);
  endtask

  task automatic test_simultaneous();
    int mc0;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 20);
    repeat (12) @(negedge clk);
    // The new edge reaches the accumulator 8 edges after being driven; tick on that edge.
    pos = (pos + 1) % 4;
    apply_pos();
    repeat (7) @(negedge clk);
    mc0 = moved_cnt;
    m_paddle = clampp(m_paddle + m_acc * 4);
    m_acc = 1;
    vSync = 1'b1;
    repeat (3) @(negedge clk);
    vSync = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (PaddleX !== 10'(m_paddle)) begin errors++; $display("FAIL simul_paddle got %0d want %0d", PaddleX, m_paddle); end
    checks++;
    if (moved_cnt - mc0 != 1) begin errors++; $display("FAIL simul_moved got %0d want 1", moved_cnt - mc0); end
    frame("simul_carry", 3);
    checks++;
    if (PaddleX !== 10'd312) begin errors++; $display("FAIL simul_carry_const got %0d want 312", PaddleX); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 10);
    frame("pre_reset", 3);
    for (int i = 0; i < 30; i++) step(1, 10);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (PaddleX !== 10'd288) begin errors++; $display("FAIL async_reset_paddle got %0d want 288", PaddleX); end
    @(negedge clk);
    rst_n = 1'b1;
    m_paddle = 288;
    m_acc = 0;
    frame("post_reset", 3);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 6);
    frame("vsync_held", 40);
    for (int i = 0; i < 3; i++) step(-1, 6);
    frame("b2b_rev", 1);
  endtask

  task automatic test_random();
    int e0;
    int n;
    int bias;
    int dir;
    e0 = err_cnt;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 60);
      bias = ($urandom_range(0, 1) == 1) ? 1 : -1;
      for (int i = 0; i < n; i++) begin
        dir = ($urandom_range(0, 99) < 75) ? bias : -bias;
        step(dir, $urandom_range(6, 20));
      end
      frame("random", $urandom_range(1, 5));
    end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL random_step_err got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_clamp();
    test_glitch();
    test_illegal();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
